// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - shares one SRAM port between buffered camera writes and VGA reads
// Reads win unless the write FIFO is full or reads have run MAX_RD_STREAK times in a row.
module sram_access_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACCESS_CYCLES = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                          clock_200mhz,
  input  logic                          RESET,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_req,
  output logic                          rd_ack,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   wr_drop_cnt
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int CNT_W    = $clog2(ACCESS_CYCLES) + 1;
  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [LVL_W-1:0]    FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state, next_state;
  logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count;
  logic [CNT_W-1:0]   cnt;
  logic [STREAK_W-1:0] streak;
  logic               grant_rd, grant_wr, push;

  always_comb begin
    next_state = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (count == FULL_LVL)                     grant_wr = 1'b1;
        else if (rd_req && (streak < STREAK_MAX))  grant_rd = 1'b1;
        else if (count != '0)                      grant_wr = 1'b1;
        else if (rd_req)                           grant_rd = 1'b1;
        if (grant_rd)      next_state = READ;
        else if (grant_wr) next_state = WRITE;
      end
      READ, WRITE: begin
        if (cnt == CNT_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rd_ack     = grant_rd;
  assign mem_read   = (state == READ);
  assign mem_write  = (state == WRITE);
  assign wr_ready   = (count < FULL_LVL);
  assign fifo_level = count;
  // Readiness uses the pre-pop count, so a full FIFO refuses even while draining.
  assign push       = wr_valid && wr_ready;

  always_ff @(posedge clock_200mhz) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock_200mhz) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock_200mhz) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cnt         <= '0;
      streak      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      wr_drop_cnt <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (grant_wr) rd_ptr <= rd_ptr + 1'b1;
      case ({push, grant_wr})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_valid && !wr_ready && (wr_drop_cnt != 16'hFFFF))
        wr_drop_cnt <= wr_drop_cnt + 1'b1;
      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + 1'b1;
      if (grant_rd) begin
        mem_addr <= rd_addr;
        if (streak != STREAK_MAX) streak <= streak + 1'b1;
      end
      if (grant_wr) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
        streak    <= '0;
      end
      if ((state == READ) && (cnt == CNT_LAST)) begin
        rd_data  <= mem_rdata;
        rd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Shares the single external SRAM controller between the camera capture path (pixel writes) and the VGA scan-out path (pixel reads). Camera writes enter a small write FIFO so that capture is not stalled. VGA reads are served with bounded latency, and a streak limit prevents writes from starving. The block sits between camera_read_data/VGA_Ctrl and topSRAM, in the clock_200mhz domain, and replaces the ad-hoc pin_pickup/pin_show_image muxing.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, pixel/SRAM word width (RGB565)
FIFO_DEPTH, 4, write FIFO entries; power of 2, minimum 2
ACCESS_CYCLES, 4, cycles mem_read/mem_write is held per access; minimum 1
MAX_RD_STREAK, 8, consecutive read grants allowed while the FIFO holds data

Ports:
clock_200mhz  in  1  sole clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
wr_valid  in  1  camera pixel write request
wr_ready  out  1  FIFO can accept; combinational, equals (count < FIFO_DEPTH)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
rd_req  in  1  VGA read request; held until acknowledged
rd_ack  out  1  combinational; rd_req accepted this cycle
rd_addr  in  ADDR_W  read address, sampled when rd_ack=1
rd_valid  out  1  one-cycle pulse; rd_data valid
rd_data  out  DATA_W  read result, held until the next rd_valid
mem_read  out  1  to topSRAM bit_Read
mem_write  out  1  to topSRAM bit_Write
mem_addr  out  ADDR_W  to topSRAM addr
mem_wdata  out  DATA_W  to topSRAM i_data
mem_rdata  in  DATA_W  from topSRAM o_data
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
wr_drop_cnt  out  16  saturating count of refused writes

Behaviour:
- Reset (RESET=1 at a rising edge) forces the following:
  - state=IDLE, FIFO emptied, rd_streak=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - rd_valid=0, rd_data=0, wr_drop_cnt=0.
  - Any access in flight is aborted: mem_read/mem_write are low from the next cycle, and no rd_valid is issued for an aborted read.
- FIFO push: occurs when wr_valid && wr_ready. wr_ready is computed from the count before any same-cycle pop, so a full FIFO refuses a push even while it pops.
- Drop counting: wr_valid && !wr_ready increments wr_drop_cnt, saturating at 16'hFFFF. The camera never stalls; refused data is lost.
- States:
  - IDLE: arbitrate.
  - READ: mem_read=1 for ACCESS_CYCLES cycles.
  - WRITE: mem_write=1 for ACCESS_CYCLES cycles.
  - mem_read and mem_write are never high together.
- Arbitration in IDLE is evaluated in this priority order:
  1. FIFO full → WRITE.
  2. rd_req && rd_streak < MAX_RD_STREAK → READ.
  3. FIFO non-empty → WRITE.
  4. rd_req → READ.
  5. Otherwise stay in IDLE.
- Read grant: rd_ack=1 in the IDLE cycle T; rd_addr is latched to mem_addr.
  - Cycles T+1..T+ACCESS_CYCLES: state=READ, mem_read=1.
  - At the end of cycle T+ACCESS_CYCLES, mem_rdata is registered into rd_data.
  - rd_valid=1 in cycle T+ACCESS_CYCLES+1, which is also an IDLE cycle, so back-to-back grants are possible.
  - Read latency is ACCESS_CYCLES+1. rd_streak increments, saturating at MAX_RD_STREAK.
- Write grant: the FIFO head is popped in IDLE cycle T; addr/data go to mem_addr/mem_wdata.
  - Cycles T+1..T+ACCESS_CYCLES: mem_write=1.
  - Return to IDLE at T+ACCESS_CYCLES+1. rd_streak clears to 0.
  - A push in the same cycle as the pop is legal when the count is below FIFO_DEPTH.
- Access period: each access occupies ACCESS_CYCLES+1 cycles including the IDLE arbitration cycle.
- Bus hold: mem_addr and mem_wdata hold their last values while in IDLE. rd_ack=0 outside IDLE.
- Address width: addresses pass through unmodified; no wrap or range check.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrapping naturally. fifo_level ranges 0..FIFO_DEPTH.

Test Plan:
- Reset: assert RESET for 2 cycles while mem_write is active → next cycle mem_write=0, fifo_level=0, wr_drop_cnt=0, rd_valid=0, and no spurious rd_valid afterwards.
- Single write: wr_valid with addr=20'h00123, data=16'hF800 into an idle block → mem_write high for exactly 4 cycles starting 2 cycles after the push, with mem_addr=20'h00123 and mem_wdata=16'hF800.
- Single read: rd_req with addr=20'h4B000 while the model returns 16'h07E0 → rd_ack the same cycle, mem_read high 4 cycles, rd_valid 5 cycles after rd_ack with rd_data=16'h07E0.
- Overflow: 6 back-to-back wr_valid pulses while rd_req is held high → wr_ready falls when fifo_level=4, wr_drop_cnt=1 or 2 per the model, and the FIFO-full condition forces a WRITE ahead of the pending read.
- Starvation: FIFO holds 1 entry, rd_req held continuously → exactly 8 read grants, then 1 write, then reads resume.
- Reset mid-read: RESET asserted at the 2nd mem_read cycle → no rd_valid afterwards, and the first post-reset read returns correct data with latency 5.
